wired_tlb_inv_walker: RTL and testbench
=======================================

WIRED_TLB_INV_WALKER -- requirements
Module: wired_tlb_inv_walker

Interface
REQ-001 SHALL have parameter TLB_ENTRIES, default 32, number of TLB entries walked; power of two, 2..256.
REQ-002 SHALL have parameter IDX_W, default $clog2(TLB_ENTRIES), entry index width.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid_i  input  1  INVTLB request valid.
REQ-007 req_ready_o  output  1  request accepted when valid&&ready.
REQ-008 req_op_i  input  5  INVTLB op code.
REQ-009 req_asid_i  input  10  ASID operand.
REQ-010 req_vppn_i  input  19  VPPN operand.
REQ-011 rd_en_o  output  1  entry key read strobe.
REQ-012 rd_idx_o  output  IDX_W  entry index read.
REQ-013 rd_key_i  input  tlb_key_t  key of rd_idx_o, valid one cycle after rd_en_o.
REQ-014 upd_o  output  1  write strobe to the entry match cell (its update_i).
REQ-015 upd_idx_o  output  IDX_W  entry written.
REQ-016 upd_key_o  output  tlb_key_t  key written (update_key_i).
REQ-017 clr_all_o  output  1  broadcast clear of every entry's e bit (FASTCLR build only; tied 0 otherwise).
REQ-018 busy_o  output  1  walk in progress.
REQ-019 done_o  output  1  one-cycle completion pulse.
REQ-020 err_o  output  1  with done_o: op code was invalid (op>6).

Function
REQ-021 SHALL implement FSM IDLE -> WALK -> DRAIN -> DONE -> IDLE; req_ready_o=1 only in IDLE.
REQ-022 SHALL latch op/asid/vppn on acceptance (cycle t); inputs ignored thereafter until IDLE.
REQ-023 Invalid op (>6): SHALL go IDLE -> DONE, done_o=1 and err_o=1 at t+1, no reads or writes.
REQ-024 WALK: cycles t+1..t+N (N=TLB_ENTRIES) SHALL assert rd_en_o with rd_idx_o=0..N-1 ascending; DRAIN is cycle t+N+1.
REQ-025 In cycles t+2..t+N+1, for key k returned, SHALL assert upd_o with upd_idx_o=k and upd_key_o=rd_key_i except e=0 iff rd_key_i.e=1 and entry selected by op.
REQ-026 Selection: op0/1 all; op2 g=1; op3 g=0; op4 g=0&&asid; op5 g=0&&asid&&va; op6 (g=1||asid)&&va.
REQ-027 asid match: key.asid==req_asid; va match: vppn[18:9] equal and (key.huge_page or vppn[8:0] equal).
REQ-028 done_o SHALL pulse at t+N+2 (DONE), err_o=0; req_ready_o returns 1 at t+N+3.
REQ-029 busy_o SHALL be 1 in WALK, DRAIN, DONE, and 0 in IDLE.
REQ-030 Write to k and read of k+1 in the same cycle is legal; no stall or back-pressure exists.
REQ-031 Upstream SHALL NOT issue other TLB writes while busy_o=1; not checked by this block.
REQ-032 Index counter SHALL stop at N-1 without wrapping; an N=2 walk is valid.

Reset
REQ-033 rst SHALL force IDLE; req_ready_o=1; rd_en_o, upd_o, clr_all_o, busy_o, done_o, err_o=0; indices 0.
REQ-034 rst mid-walk SHALL abort with no done_o; entries already written stay written.

Configuration
REQ-035 With WIRED_TLB_INV_FASTCLR_EN defined, op0/op1 SHALL assert clr_all_o at t+1 only, no rd_en_o/upd_o, done_o at t+2, ready at t+3.
REQ-036 Without WIRED_TLB_INV_FASTCLR_EN, op0/op1 SHALL walk as REQ-024..028 and clr_all_o SHALL be constant 0.

Structure
REQ-037 tlb_key_t (e, g, asid[9:0], vppn[18:0], huge_page) and INVTLB op constants SHALL live in the shared wired package.
REQ-038 Selection logic SHALL be one combinational sub-module wired_tlb_inv_sel (key + latched operands -> sel); FSM/counters stay in the top.

Verification (N=32)
REQ-039 op3; entries 0..31 valid, even g=1 -> 16 upd_o to odd indices, done_o at t+34, err_o=0.
REQ-040 op5 asid=0x05 vppn=0x12345; entry 7 g=0 asid5 exact vppn, entry 9 huge vppn[18:9] equal, entry 11 asid6 -> upd at idx 7 (t+9) and 9 (t+11) only.
REQ-041 op7 -> done_o=err_o=1 at t+1, no rd_en_o.
REQ-042 rst asserted at t+10 of op0 walk -> outputs reset next cycle, no done_o; new request accepted afterwards completes normally.
REQ-043 FASTCLR build, op1 -> clr_all_o at t+1 only, done_o at t+2; non-FASTCLR build -> 32 reads, upd for every e=1 entry.
REQ-044 Back-to-back: req_valid held high -> second accepted exactly at t+N+3, walks again from index 0.

Source files
------------

// File: rtl/wired_tlb_inv_walker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wired_tlb_inv_walker_pkg
// Description : Shared TLB definitions: entry key layout, INVTLB op codes and
//               the walker state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package wired_tlb_inv_walker_pkg;

    // Key stored in every TLB entry match cell.
    typedef struct packed {
        logic        e;          // entry valid
        logic        g;          // global mapping, ignores ASID
        logic [9:0]  asid;
        logic [18:0] vppn;
        logic        huge_page;  // only vppn[18:9] takes part in VA match
    } tlb_key_t;

    // INVTLB op codes; anything above c_OP_MAX is rejected.
    localparam logic [4:0] c_OP_CLR_ALL       = 5'd0;
    localparam logic [4:0] c_OP_CLR_ALL_ALT   = 5'd1;
    localparam logic [4:0] c_OP_CLR_GLOBAL    = 5'd2;
    localparam logic [4:0] c_OP_CLR_NONGLOBAL = 5'd3;
    localparam logic [4:0] c_OP_CLR_ASID      = 5'd4;
    localparam logic [4:0] c_OP_CLR_ASID_VA   = 5'd5;
    localparam logic [4:0] c_OP_CLR_GASID_VA  = 5'd6;
    localparam logic [4:0] c_OP_MAX           = 5'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WALK  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } walk_state_t;

endpackage
`default_nettype wire

// File: rtl/wired_tlb_inv_walker_sel.sv
`default_nettype none
// ============================================================================
// Module      : wired_tlb_inv_sel
// Description : Combinational INVTLB entry selection. Decides whether the key
//               read from one TLB entry is targeted by the latched op/operands.
// Ports       : key_i   - key read from the entry
//               op_i    - latched INVTLB op code
//               asid_i  - latched ASID operand
//               vppn_i  - latched VPPN operand
//               sel_o   - entry is selected for invalidation
// Revision    : 1.0 - initial release
// ============================================================================
module wired_tlb_inv_sel
    import wired_tlb_inv_walker_pkg::*;
(
    input  tlb_key_t    key_i,
    input  logic [4:0]  op_i,
    input  logic [9:0]  asid_i,
    input  logic [18:0] vppn_i,
    output logic        sel_o
);

    logic w_asid_hit;
    logic w_va_hit;

    assign w_asid_hit = (key_i.asid == asid_i);
    // Huge pages cover 2^9 small pages, so the low VPPN bits are don't-care.
    assign w_va_hit   = (key_i.vppn[18:9] == vppn_i[18:9]) &&
                        (key_i.huge_page || (key_i.vppn[8:0] == vppn_i[8:0]));

    always_comb begin
        sel_o = 1'b0;
        case (op_i)
            c_OP_CLR_ALL,
            c_OP_CLR_ALL_ALT:   sel_o = 1'b1;
            c_OP_CLR_GLOBAL:    sel_o = key_i.g;
            c_OP_CLR_NONGLOBAL: sel_o = !key_i.g;
            c_OP_CLR_ASID:      sel_o = !key_i.g && w_asid_hit;
            c_OP_CLR_ASID_VA:   sel_o = !key_i.g && w_asid_hit && w_va_hit;
            c_OP_CLR_GASID_VA:  sel_o = (key_i.g || w_asid_hit) && w_va_hit;
            default:            sel_o = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wired_tlb_inv_walker.sv
`default_nettype none
// ============================================================================
// Module      : wired_tlb_inv_walker
// Description : INVTLB walker. Accepts one invalidate request, reads every TLB
//               entry key in ascending order and writes back selected valid
//               entries with e cleared, then pulses done_o.
// Build macro : WIRED_TLB_INV_FASTCLR_EN - op0/op1 use a single-cycle
//               broadcast clear (clr_all_o) instead of a walk.
// Ports       : req_*      - request handshake and operands
//               rd_en_o/rd_idx_o/rd_key_i - key read port (1-cycle latency)
//               upd_o/upd_idx_o/upd_key_o - key write port
//               clr_all_o  - broadcast e-bit clear (fast-clear build only)
//               busy_o/done_o/err_o      - status
// Revision    : 1.0 - initial release
// ============================================================================
module wired_tlb_inv_walker
    import wired_tlb_inv_walker_pkg::*;
#(
    parameter int TLB_ENTRIES = 32,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [4:0]       req_op_i,
    input  logic [9:0]       req_asid_i,
    input  logic [18:0]      req_vppn_i,
    output logic             rd_en_o,
    output logic [IDX_W-1:0] rd_idx_o,
    input  tlb_key_t         rd_key_i,
    output logic             upd_o,
    output logic [IDX_W-1:0] upd_idx_o,
    output tlb_key_t         upd_key_o,
    output logic             clr_all_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(TLB_ENTRIES - 1);

    walk_state_t      r_state;
    walk_state_t      w_state_nxt;
    logic [4:0]       r_op;
    logic [9:0]       r_asid;
    logic [18:0]      r_vppn;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_upd_idx;
    logic             r_rd_pend;
    logic             r_err;
    logic             w_accept;
    logic             w_op_bad;
    logic             w_op_fast;
    logic             w_sel;

    assign w_accept = req_valid_i && (r_state == S_IDLE);
    assign w_op_bad = (req_op_i > c_OP_MAX);

`ifdef WIRED_TLB_INV_FASTCLR_EN
    logic r_fast;

    assign w_op_fast = (req_op_i == c_OP_CLR_ALL) || (req_op_i == c_OP_CLR_ALL_ALT);
    // The fast path borrows DRAIN as its single working cycle; no reads are
    // outstanding there, so the broadcast cannot collide with a write-back.
    assign clr_all_o = (r_state == S_DRAIN) && r_fast;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fast <= 1'b0;
        end else if (w_accept) begin
            r_fast <= w_op_fast;
        end
    end
`else
    assign w_op_fast = 1'b0;
    assign clr_all_o = 1'b0;
`endif

    // ---------------------------------------------------------------- FSM
    always_comb begin
        w_state_nxt = r_state;
        req_ready_o = 1'b0;
        rd_en_o     = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (req_valid_i) begin
                    if (w_op_bad) begin
                        w_state_nxt = S_DONE;
                    end else if (w_op_fast) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_state_nxt = S_WALK;
                    end
                end
            end
            S_WALK: begin
                rd_en_o = 1'b1;
                if (r_idx == c_LAST_IDX) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_asid    <= '0;
            r_vppn    <= '0;
            r_idx     <= '0;
            r_upd_idx <= '0;
            r_rd_pend <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            // Key for the index read this cycle returns next cycle; track it.
            r_rd_pend <= rd_en_o;
            r_upd_idx <= r_idx;
            if (w_accept) begin
                r_op   <= req_op_i;
                r_asid <= req_asid_i;
                r_vppn <= req_vppn_i;
                r_idx  <= '0;
                r_err  <= w_op_bad;
            end else if ((r_state == S_WALK) && (r_idx != c_LAST_IDX)) begin
                // Saturate at the last entry so narrow IDX_W never wraps.
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    // ------------------------------------------------------- write-back path
    wired_tlb_inv_sel u_sel (
        .key_i  (rd_key_i),
        .op_i   (r_op),
        .asid_i (r_asid),
        .vppn_i (r_vppn),
        .sel_o  (w_sel)
    );

    always_comb begin
        upd_key_o   = rd_key_i;
        upd_key_o.e = 1'b0;
    end

    // Only entries that are actually valid and selected get written.
    assign upd_o     = r_rd_pend && rd_key_i.e && w_sel;
    assign upd_idx_o = r_upd_idx;
    assign rd_idx_o  = r_idx;
    assign err_o     = done_o && r_err;

endmodule
`default_nettype wire

// File: tb/tb_wired_tlb_inv_walker.sv
`default_nettype none
// ============================================================================
// Module      : tb_wired_tlb_inv_walker
// Description : Self-checking bench for wired_tlb_inv_walker with a TLB key
//               array model, a spec-level reference and a scoreboard monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wired_tlb_inv_walker;
    import wired_tlb_inv_walker_pkg::*;

    localparam int N  = 32;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [4:0]    req_op_i;
    logic [9:0]    req_asid_i;
    logic [18:0]   req_vppn_i;
    logic          rd_en_o;
    logic [IW-1:0] rd_idx_o;
    tlb_key_t      rd_key_i = '0;
    logic          upd_o;
    logic [IW-1:0] upd_idx_o;
    tlb_key_t      upd_key_o;
    logic          clr_all_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    always #5 clk = ~clk;

    wired_tlb_inv_walker #(.TLB_ENTRIES(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_i    (req_op_i),
        .req_asid_i  (req_asid_i),
        .req_vppn_i  (req_vppn_i),
        .rd_en_o     (rd_en_o),
        .rd_idx_o    (rd_idx_o),
        .rd_key_i    (rd_key_i),
        .upd_o       (upd_o),
        .upd_idx_o   (upd_idx_o),
        .upd_key_o   (upd_key_o),
        .clr_all_o   (clr_all_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------ TLB array
    tlb_key_t mem      [N];
    tlb_key_t load_img [N];
    tlb_key_t ref_img  [N];
    logic     load_pulse = 1'b0;

    always @(posedge clk) begin
        if (rd_en_o) rd_key_i <= mem[rd_idx_o];
        if (load_pulse) begin
            for (int i = 0; i < N; i++) mem[i] <= load_img[i];
        end else if (upd_o) begin
            mem[upd_idx_o] <= upd_key_o;
        end
    end

    // ------------------------------------------------------------ scoreboard
    typedef struct {
        int       kind;   // 0 write-back, 1 broadcast clear, 2 completion
        int       idx;
        tlb_key_t key;
        logic     err;
    } exp_t;

    exp_t sbq[$];
    int   acc_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit is_fast(input int op);
`ifdef WIRED_TLB_INV_FASTCLR_EN
        return (op == 0) || (op == 1);
`else
        return (op < 0);
`endif
    endfunction

    function automatic bit walks(input int op);
        return (op <= 6) && !is_fast(op);
    endfunction

    function automatic bit selected(input tlb_key_t k, input int op,
                                    input logic [9:0] asid, input logic [18:0] vppn);
        bit am;
        bit vm;
        am = (k.asid == asid);
        vm = (k.vppn[18:9] == vppn[18:9]) && (k.huge_page || (k.vppn[8:0] == vppn[8:0]));
        case (op)
            0, 1:    return 1'b1;
            2:       return k.g;
            3:       return !k.g;
            4:       return !k.g && am;
            5:       return !k.g && am && vm;
            6:       return (k.g || am) && vm;
            default: return 1'b0;
        endcase
    endfunction

    // Reference: list every write the request must cause, then its completion.
    task automatic model_req(input int op, input logic [9:0] asid, input logic [18:0] vppn);
        exp_t e;
        exp_t u;
        e.kind = 2; e.idx = 0; e.key = '0; e.err = (op > 6);
        if (op <= 6) begin
            if (is_fast(op)) begin
                u = e; u.kind = 1; u.err = 1'b0;
                sbq.push_back(u);
                for (int i = 0; i < N; i++) ref_img[i].e = 1'b0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (ref_img[i].e && selected(ref_img[i], op, asid, vppn)) begin
                        u.kind = 0; u.idx = i; u.key = ref_img[i]; u.key.e = 1'b0; u.err = 1'b0;
                        ref_img[i].e = 1'b0;
                        sbq.push_back(u);
                    end
                end
            end
        end
        sbq.push_back(e);
    endtask

    // ------------------------------------------------------------ monitor
    int acc_t  = -1000;
    int acc_op = 0;
    int rd_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (req_valid_i && req_ready_o) begin
                acc_t  = cyc;
                acc_op = int'(req_op_i);
                rd_cnt = 0;
                acc_q.push_back(cyc);
            end
            if (err_o && !done_o) chk("err_only_with_done", 64'(done_o), 64'(1));
            if (rd_en_o) begin
                chk("rd_legal", 64'(walks(acc_op)), 64'(1));
                chk("rd_idx", 64'(rd_idx_o), 64'(cyc - acc_t - 1));
                rd_cnt++;
            end
            if (upd_o) begin
                chk("upd_expected", 64'(sbq.size() > 0), 64'(1));
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("upd_kind", 64'(e.kind), 64'(0));
                    chk("upd_idx", 64'(upd_idx_o), 64'(e.idx));
                    chk("upd_key", 64'(upd_key_o), 64'(e.key));
                    chk("upd_cycle", 64'(cyc), 64'(acc_t + 2 + e.idx));
                    chk("busy_walk", 64'(busy_o), 64'(1));
                end
            end
            if (clr_all_o) begin
                chk("clr_expected", 64'(sbq.size() > 0), 64'(1));
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("clr_kind", 64'(e.kind), 64'(1));
                    chk("clr_cycle", 64'(cyc), 64'(acc_t + 1));
                end
            end
            if (done_o) begin
                chk("done_expected", 64'(sbq.size() > 0), 64'(1));
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("done_kind", 64'(e.kind), 64'(2));
                    chk("done_err", 64'(err_o), 64'(e.err));
                    chk("done_cycle", 64'(cyc),
                        64'(acc_t + ((acc_op > 6) ? 1 : (is_fast(acc_op) ? 2 : N + 2))));
                    chk("read_count", 64'(rd_cnt), 64'(walks(acc_op) ? N : 0));
                    chk("busy_at_done", 64'(busy_o), 64'(1));
                    chk("ready_at_done", 64'(req_ready_o), 64'(0));
                end
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic commit_img();
        for (int i = 0; i < N; i++) ref_img[i] = load_img[i];
        load_pulse = 1'b1;
        @(posedge clk); #1;
        load_pulse = 1'b0;
    endtask

    function automatic logic [18:0] pick_vppn();
        logic [18:0] v;
        v = 19'($urandom);
        if ($urandom_range(1, 0) == 1) v[18:9] = 10'h091;
        if ($urandom_range(1, 0) == 1) v[8:0]  = 9'h145;
        return v;
    endfunction

    function automatic logic [9:0] pick_asid();
        case ($urandom_range(2, 0))
            0:       return 10'h005;
            1:       return 10'h006;
            default: return 10'($urandom);
        endcase
    endfunction

    task automatic load_random();
        for (int i = 0; i < N; i++) begin
            load_img[i].e         = ($urandom_range(3, 0) != 0);
            load_img[i].g         = 1'($urandom);
            load_img[i].asid      = pick_asid();
            load_img[i].vppn      = pick_vppn();
            load_img[i].huge_page = 1'($urandom);
        end
        commit_img();
    endtask

    task automatic issue(input int op, input logic [9:0] asid, input logic [18:0] vppn);
        model_req(op, asid, vppn);
        req_op_i    = 5'(op);
        req_asid_i  = asid;
        req_vppn_i  = vppn;
        req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        // Operands must be ignored once latched.
        req_op_i   = 5'($urandom);
        req_asid_i = 10'($urandom);
        req_vppn_i = 19'($urandom);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!((sbq.size() == 0) && req_ready_o) && (k < 400)) begin
            @(posedge clk); #1;
            k++;
        end
        chk("idle_reached", 64'((sbq.size() == 0) && req_ready_o), 64'(1));
        if (sbq.size() != 0) sbq.delete();
    endtask

    task automatic check_mem();
        int bad;
        bad = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== ref_img[i]) bad++;
        chk("mem_image", 64'(bad), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"},   64'(req_ready_o), 64'(1));
        chk({tag, "_busy"},    64'(busy_o),      64'(0));
        chk({tag, "_rd_en"},   64'(rd_en_o),     64'(0));
        chk({tag, "_upd"},     64'(upd_o),       64'(0));
        chk({tag, "_clr"},     64'(clr_all_o),   64'(0));
        chk({tag, "_done"},    64'(done_o),      64'(0));
        chk({tag, "_err"},     64'(err_o),       64'(0));
        chk({tag, "_rd_idx"},  64'(rd_idx_o),    64'(0));
        chk({tag, "_upd_idx"}, 64'(upd_idx_o),   64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        int t0;
        int k;
        rst         = 1'b1;
        req_valid_i = 1'b0;
        req_op_i    = '0;
        req_asid_i  = '0;
        req_vppn_i  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;

        // op3: even entries global, odd entries get cleared.
        for (int i = 0; i < N; i++) begin
            load_img[i].e = 1'b1; load_img[i].g = ((i % 2) == 0);
            load_img[i].asid = pick_asid(); load_img[i].vppn = pick_vppn();
            load_img[i].huge_page = 1'($urandom);
        end
        commit_img();
        issue(3, 10'h005, 19'h12345);
        wait_idle();
        check_mem();

        // op5 asid/VA match with exact, huge-page and wrong-ASID candidates.
        for (int i = 0; i < N; i++) begin
            load_img[i].e = 1'b1; load_img[i].g = 1'b1; load_img[i].asid = 10'h005;
            load_img[i].vppn = 19'h12345; load_img[i].huge_page = 1'b0;
        end
        load_img[7]  = '{e: 1'b1, g: 1'b0, asid: 10'h005, vppn: 19'h12345, huge_page: 1'b0};
        load_img[9]  = '{e: 1'b1, g: 1'b0, asid: 10'h005, vppn: {10'h091, 9'h0AA}, huge_page: 1'b1};
        load_img[11] = '{e: 1'b1, g: 1'b0, asid: 10'h006, vppn: 19'h12345, huge_page: 1'b0};
        load_img[13] = '{e: 1'b1, g: 1'b0, asid: 10'h005, vppn: {10'h091, 9'h0AA}, huge_page: 1'b0};
        commit_img();
        issue(5, 10'h005, 19'h12345);
        wait_idle();
        check_mem();

        // Invalid op: immediate error completion, no array traffic.
        issue(7, 10'h000, 19'h00000);
        wait_idle();
        issue(31, 10'h3FF, 19'h7FFFF);
        wait_idle();

        // op1 over a mixed image.
        load_random();
        issue(1, pick_asid(), pick_vppn());
        wait_idle();
        check_mem();

        // Reset in the middle of a walk aborts without completion.
        load_random();
        op = is_fast(0) ? 2 : 0;
        t0 = cyc;
        issue(op, 10'h005, 19'h12345);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sbq.delete();
        @(negedge clk);
        check_reset_outputs("abort");
        chk("abort_timing", 64'(cyc - t0), 64'(11));
        repeat (N + 4) @(posedge clk);
        #1;
        load_random();
        issue(0, 10'h000, 19'h00000);
        wait_idle();
        check_mem();

        // Back-to-back: valid held high across two requests.
        load_random();
        acc_q.delete();
        model_req(4, 10'h005, 19'h0);
        model_req(6, 10'h006, 19'h12345);
        req_op_i = 5'd4; req_asid_i = 10'h005; req_vppn_i = 19'h0;
        req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_op_i = 5'd6; req_asid_i = 10'h006; req_vppn_i = 19'h12345;
        k = 0;
        while ((acc_q.size() < 2) && (k < 200)) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        chk("b2b_accepts", 64'(acc_q.size()), 64'(2));
        if (acc_q.size() >= 2) chk("b2b_gap", 64'(acc_q[1] - acc_q[0]), 64'(N + 3));
        wait_idle();
        check_mem();

        // Randomized requests.
        for (int n = 0; n < 16; n++) begin
            load_random();
            op = ($urandom_range(3, 0) == 0) ? int'($urandom_range(31, 0))
                                              : int'($urandom_range(6, 0));
            issue(op, pick_asid(), pick_vppn());
            wait_idle();
            check_mem();
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
